// File: rtl/img_mem_sequencer_pkg.sv
// img_seq_pkg: shared constants for the image memory sequencer.
//   State codes for the load/run/unload controller and the processor
//   `status` mode encoding.
package img_seq_pkg;

  // Controller states (legacy-style constant encoding)
  localparam logic [2:0] StateIdle       = 3'd0;
  localparam logic [2:0] StateLoad       = 3'd1;
  localparam logic [2:0] StateRun        = 3'd2;
  localparam logic [2:0] StateUnloadAddr = 3'd3;
  localparam logic [2:0] StateUnloadWait = 3'd4;
  localparam logic [2:0] StateUnloadSend = 3'd5;
  localparam logic [2:0] StateDone       = 3'd6;

  // Processor mode lines
  localparam logic [1:0] ST_IDLE   = 2'b00;
  localparam logic [1:0] ST_RUN    = 2'b01;
  localparam logic [1:0] ST_LOAD   = 2'b10;
  localparam logic [1:0] ST_UNLOAD = 2'b11;

endpackage

// File: rtl/img_mem_sequencer_if.sv
// img_seq_if: host byte link of the image memory sequencer.
//   rx_data/rx_valid/rx_ready : image bytes host -> sequencer
//   tx_data/tx_valid/tx_ready : result bytes sequencer -> host
//   master = host side, slave = sequencer side.
interface img_seq_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (
    output rx_data, rx_valid, tx_ready,
    input  rx_ready, tx_data, tx_valid
  );

  modport slave (
    input  rx_data, rx_valid, tx_ready,
    output rx_ready, tx_data, tx_valid
  );
endinterface

// File: rtl/img_mem_sequencer_seq_byte_counter.sv
// seq_byte_counter: W+1 bit byte counter with terminal-count detect.
//   clk, rst : clock, synchronous active-high reset
//   clr      : synchronous clear (wins over inc)
//   inc      : increment by one
//   limit    : transfer length; last is high while count == limit-1
//   count    : low W bits of the count (used as a memory offset)
module seq_byte_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  input  logic [W:0]   limit,
  output logic [W-1:0] count,
  output logic         last
);

  logic [W:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt_q <= '0;
    end else if (inc) begin
      cnt_q <= cnt_q + {{W{1'b0}}, 1'b1};
    end
  end

  assign count = cnt_q[W-1:0];
  // Extra counter bit lets limit reach 2^W
  assign last  = ((cnt_q + {{W{1'b0}}, 1'b1}) == limit);

endmodule

// File: rtl/img_mem_sequencer.sv
// img_mem_sequencer: load / run / unload mode controller for the downsampler.
//   clk, rst     : clock, synchronous active-high reset
//   start        : begin a sequence (IDLE only)
//   host         : byte link (rx image in, tx result out), img_seq_if.slave
//   status       : processor mode 00 idle, 10 load, 01 run, 11 unload
//   data_addr_in : data memory address, data_in : byte written during load
//   end_process  : processor finished, dm_out : data memory read data
//   busy, done   : not idle / one-cycle end-of-sequence pulse
//   error        : sticky run watchdog flag
// Optional: define IMG_SEQ_WATCHDOG_EN to enable the RUN timeout watchdog.
module img_mem_sequencer
  import img_seq_pkg::*;
#(
  parameter int unsigned       ADDR_W      = 16,
  parameter int unsigned       IN_LEN      = 4096,
  parameter logic [ADDR_W-1:0] OUT_BASE    = 16'h1000,
  parameter int unsigned       OUT_LEN     = 1024,
  parameter int unsigned       RD_LAT      = 2,
  parameter int unsigned       RUN_TIMEOUT = 1000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  img_seq_if.slave          host,
  output logic [1:0]        status,
  output logic [ADDR_W-1:0] data_addr_in,
  output logic [7:0]        data_in,
  input  logic              end_process,
  input  logic [7:0]        dm_out,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam int unsigned WaitW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  logic [2:0]        state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        data_in_q;
  logic [7:0]        tx_data_q;
  logic              tx_valid_q;
  logic [WaitW-1:0]  wait_q;

  logic              cnt_clr, cnt_inc, cnt_last;
  logic [ADDR_W:0]   cnt_limit;
  logic [ADDR_W-1:0] cnt;
  logic              wd_expire;

  always_comb begin
    cnt_clr   = (state_q == StateIdle && start) || (state_q == StateRun && end_process);
    cnt_inc   = (state_q == StateLoad && host.rx_valid) ||
                (state_q == StateUnloadSend && tx_valid_q && host.tx_ready);
    cnt_limit = (state_q == StateLoad) ? (ADDR_W+1)'(IN_LEN) : (ADDR_W+1)'(OUT_LEN);
  end

  seq_byte_counter #(
    .W (ADDR_W)
  ) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (cnt_clr),
    .inc   (cnt_inc),
    .limit (cnt_limit),
    .count (cnt),
    .last  (cnt_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StateIdle;
      addr_q     <= '0;
      data_in_q  <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      wait_q     <= '0;
    end else begin
      unique case (state_q)
        StateIdle: begin
          if (start) state_q <= (IN_LEN == 0) ? StateRun : StateLoad;
        end
        StateLoad: begin
          if (host.rx_valid) begin
            data_in_q <= host.rx_data;
            addr_q    <= cnt;
            if (cnt_last) state_q <= StateRun;
          end
        end
        StateRun: begin
          // end_process wins over a simultaneous timeout
          if (end_process) state_q <= (OUT_LEN == 0) ? StateDone : StateUnloadAddr;
          else if (wd_expire) state_q <= StateDone;
        end
        StateUnloadAddr: begin
          addr_q  <= OUT_BASE + cnt;
          wait_q  <= '0;
          state_q <= StateUnloadWait;
        end
        StateUnloadWait: begin
          // dm_out is valid at the RD_LAT-th edge after the address change
          if (wait_q == WaitW'(RD_LAT - 1)) begin
            tx_data_q  <= dm_out;
            tx_valid_q <= 1'b1;
            state_q    <= StateUnloadSend;
          end else begin
            wait_q <= wait_q + 1'b1;
          end
        end
        StateUnloadSend: begin
          if (host.tx_ready) begin
            tx_valid_q <= 1'b0;
            state_q    <= cnt_last ? StateDone : StateUnloadAddr;
          end
        end
        StateDone: state_q <= StateIdle;
        default:   state_q <= StateIdle;
      endcase
    end
  end

`ifdef IMG_SEQ_WATCHDOG_EN
  localparam int unsigned WdW = (RUN_TIMEOUT > 1) ? $clog2(RUN_TIMEOUT) : 1;

  logic [WdW-1:0] wd_q;
  logic           error_q;

  assign wd_expire = (state_q == StateRun) && (wd_q == WdW'(RUN_TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      wd_q    <= '0;
      error_q <= 1'b0;
    end else begin
      if (state_q == StateIdle && start) error_q <= 1'b0;
      // Counter idles at zero outside RUN, so it starts fresh on entry
      if (state_q != StateRun) begin
        wd_q <= '0;
      end else if (!end_process) begin
        if (wd_expire) error_q <= 1'b1;
        else           wd_q    <= wd_q + 1'b1;
      end
    end
  end

  assign error = error_q;
`else
  assign wd_expire = 1'b0;
  assign error     = 1'b0;
`endif

  always_comb begin
    unique case (state_q)
      StateLoad:                                         status = ST_LOAD;
      StateRun:                                          status = ST_RUN;
      StateUnloadAddr, StateUnloadWait, StateUnloadSend: status = ST_UNLOAD;
      default:                                           status = ST_IDLE;
    endcase
  end

  assign host.rx_ready = (state_q == StateLoad);
  assign host.tx_data  = tx_data_q;
  assign host.tx_valid = tx_valid_q;
  assign data_addr_in  = addr_q;
  assign data_in       = data_in_q;
  assign busy          = (state_q != StateIdle);
  assign done          = (state_q == StateDone);

endmodule

// File: tb/tb_img_mem_sequencer.sv
// tb_img_mem_sequencer: directed bench for img_mem_sequencer.
//   IN_LEN=4, OUT_BASE=16'h1000, OUT_LEN=3, RD_LAT=2, RUN_TIMEOUT=100.
//   Memory model returns the low address byte, sampled by the DUT at the
//   second edge after data_addr_in changes.
module tb_img_mem_sequencer;

  localparam int unsigned AW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          end_process = 1'b0;
  logic [1:0]    status;
  logic [AW-1:0] data_addr_in;
  logic [7:0]    data_in;
  logic [7:0]    dm_out;
  logic          busy, done, error;

  int n_checks = 0;
  int n_pass   = 0;

  img_seq_if bus ();

  img_mem_sequencer #(
    .ADDR_W      (AW),
    .IN_LEN      (4),
    .OUT_BASE    (16'h1000),
    .OUT_LEN     (3),
    .RD_LAT      (2),
    .RUN_TIMEOUT (100)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .host         (bus),
    .status       (status),
    .data_addr_in (data_addr_in),
    .data_in      (data_in),
    .end_process  (end_process),
    .dm_out       (dm_out),
    .busy         (busy),
    .done         (done),
    .error        (error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) dm_out <= data_addr_in[7:0];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Four load beats; with gap=1 rx_valid idles one cycle before each beat
  task automatic load4(input logic [7:0] base, input bit gap);
    for (int i = 0; i < 4; i++) begin
      if (gap) begin
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'hEE;
        @(negedge clk);
        if (i > 0) begin
          check("gap_addr_hold", 32'(data_addr_in), 32'(i - 1));
          check("gap_data_hold", 32'(data_in), 32'(base + 8'(i - 1)));
        end
      end
      check("load_status", 32'(status), 32'h2);
      check("load_rx_ready", 32'(bus.rx_ready), 32'h1);
      bus.rx_valid = 1'b1;
      bus.rx_data  = base + 8'(i);
      @(negedge clk);
      check("load_addr", 32'(data_addr_in), 32'(i));
      check("load_data", 32'(data_in), 32'(base + 8'(i)));
    end
    bus.rx_valid = 1'b0;
    check("run_status", 32'(status), 32'h1);
    check("run_rx_ready", 32'(bus.rx_ready), 32'h0);
  endtask

  task automatic wait_tx(input string tag);
    int budget = 20;
    while (!bus.tx_valid && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (!bus.tx_valid) check(tag, 32'h0, 32'h1);
  endtask

  // One unload byte k, with tx_ready held low for hold cycles first
  task automatic unload_byte(input int k, input int hold);
    wait_tx("tx_valid_timeout");
    check("tx_data", 32'(bus.tx_data), 32'(k));
    check("unload_status", 32'(status), 32'h3);
    check("unload_addr", 32'(data_addr_in), 32'h1000 + 32'(k));
    for (int j = 0; j < hold; j++) begin
      @(negedge clk);
      check("hold_tx_valid", 32'(bus.tx_valid), 32'h1);
      check("hold_tx_data", 32'(bus.tx_data), 32'(k));
      check("hold_addr", 32'(data_addr_in), 32'h1000 + 32'(k));
    end
    bus.tx_ready = 1'b1;
    @(negedge clk);
    bus.tx_ready = 1'b0;
    check("tx_valid_drop", 32'(bus.tx_valid), 32'h0);
  endtask

  task automatic finish_seq();
    check("done_pulse", 32'(done), 32'h1);
    check("done_status", 32'(status), 32'h0);
    @(negedge clk);
    check("done_once", 32'(done), 32'h0);
    check("idle_busy", 32'(busy), 32'h0);
    check("idle_status", 32'(status), 32'h0);
  endtask

  initial begin
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    bus.tx_ready = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_status", 32'(status), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_error", 32'(error), 32'h0);
    check("rst_rx_ready", 32'(bus.rx_ready), 32'h0);
    check("rst_tx_valid", 32'(bus.tx_valid), 32'h0);
    check("rst_tx_data", 32'(bus.tx_data), 32'h0);
    check("rst_addr", 32'(data_addr_in), 32'h0);
    check("rst_data_in", 32'(data_in), 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // Sequence A: back-to-back load, run 50 cycles, unload with a stall
    pulse_start();
    check("start_busy", 32'(busy), 32'h1);
    load4(8'hA0, 1'b0);
    pulse_start();
    check("start_ignored_run", 32'(status), 32'h1);
    repeat (48) @(negedge clk);
    check("run_addr_hold", 32'(data_addr_in), 32'h3);
    check("run_status_50", 32'(status), 32'h1);
    end_process = 1'b1;
    @(negedge clk);
    end_process = 1'b0;
    check("unload_entry", 32'(status), 32'h3);
    unload_byte(0, 0);
    unload_byte(1, 10);
    unload_byte(2, 0);
    finish_seq();

    // Sequence B: gapped load, end_process already high, reset mid-unload
    pulse_start();
    end_process = 1'b1;
    load4(8'hB0, 1'b1);
    wait_tx("tx_valid_timeout_b");
    check("b_unload_status", 32'(status), 32'h3);
    rst = 1'b1;
    @(negedge clk);
    check("abort_status", 32'(status), 32'h0);
    check("abort_tx_valid", 32'(bus.tx_valid), 32'h0);
    check("abort_busy", 32'(busy), 32'h0);
    rst = 1'b0;
    end_process = 1'b0;
    @(negedge clk);

    // Sequence C: fresh load from address 0, then run without end_process
    pulse_start();
    load4(8'hC0, 1'b0);
`ifdef IMG_SEQ_WATCHDOG_EN
    begin
      int cycles = 0;
      bit tx_seen = 1'b0;
      while (!done && cycles < 300) begin
        if (bus.tx_valid) tx_seen = 1'b1;
        @(negedge clk);
        cycles++;
      end
      check("wd_cycles", 32'(cycles), 32'd100);
      check("wd_error", 32'(error), 32'h1);
      check("wd_no_tx", 32'(tx_seen), 32'h0);
      finish_seq();
      check("wd_error_sticky", 32'(error), 32'h1);
      pulse_start();
      check("wd_error_cleared", 32'(error), 32'h0);
      check("wd_restart_status", 32'(status), 32'h2);
    end
`else
    repeat (150) @(negedge clk);
    check("nowd_still_run", 32'(status), 32'h1);
    check("nowd_error", 32'(error), 32'h0);
    check("nowd_tx_valid", 32'(bus.tx_valid), 32'h0);
    end_process = 1'b1;
    @(negedge clk);
    end_process = 1'b0;
    unload_byte(0, 0);
    unload_byte(1, 0);
    unload_byte(2, 0);
    finish_seq();
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
